// File: rtl/jtmikie_vtiming.sv
// jtmikie_vtiming: raster timing generator for the Mikie video pipeline.
// Counts pixel-clock enables into hdump/vdump and produces registered blanking,
// sync and line-start strobes that change on the same edge as the counter value
// that causes them.
// Optional feature macro: JTMIKIE_VTIMING_SHIFT_EN adds signed 4-bit hoffset /
// voffset inputs that move the HS / VS windows. The offsets are captured only
// at the frame wrap.
module jtmikie_vtiming #(
    parameter logic [8:0] HCNT_START = 9'h080,
    parameter logic [8:0] HCNT_END   = 9'h1FF,
    parameter logic [8:0] VCNT_START = 9'h0F8,
    parameter logic [8:0] VCNT_END   = 9'h1FF,
    parameter logic [8:0] HB_START   = 9'h080,
    parameter logic [8:0] HB_END     = 9'h100,
    parameter logic [8:0] HS_START   = 9'h0B0,
    parameter logic [8:0] HS_END     = 9'h0D0,
    parameter logic [8:0] VB_START   = 9'h1F0,
    parameter logic [8:0] VB_END     = 9'h110,
    parameter logic [8:0] VS_START   = 9'h1F8,
    parameter logic [8:0] VS_END     = 9'h100,
    parameter logic [8:0] HINIT_POS  = 9'h080
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
`ifdef JTMIKIE_VTIMING_SHIFT_EN
    input  logic [3:0] hoffset,
    input  logic [3:0] voffset,
`endif
    output logic [8:0] hdump,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic       hinit,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS
);

    // Wrapping counter step: last value reloads the first one.
    function automatic logic [8:0] cnt_next(input logic [8:0] cur,
                                            input logic [8:0] first,
                                            input logic [8:0] last);
        logic [8:0] nxt;
        if (cur == last) begin
            nxt = first;
        end else begin
            nxt = cur + 9'd1;
        end
        return nxt;
    endfunction

    // Set/clear flag driven by the position the counter is about to take.
    // Positions outside the counter range never match, so the flag holds.
    function automatic logic flag_update(input logic       cur,
                                         input logic [8:0] pos,
                                         input logic [8:0] set_pos,
                                         input logic [8:0] clr_pos);
        logic nxt;
        if (pos == set_pos) begin
            nxt = 1'b1;
        end else if (pos == clr_pos) begin
            nxt = 1'b0;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic [8:0] hdump_q, hdump_d;
    logic [8:0] vdump_q, vdump_d;
    logic [8:0] vrender_q, vrender_d;
    logic       hinit_q, hinit_d;
    logic       lhbl_q, lhbl_d;
    logic       lvbl_q, lvbl_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    logic       h_wrap_s;
    logic       v_wrap_s;
    logic [8:0] hs_start_s, hs_end_s;
    logic [8:0] vs_start_s, vs_end_s;

    assign h_wrap_s = (hdump_q == HCNT_END);
    assign v_wrap_s = (vdump_q == VCNT_END);

`ifdef JTMIKIE_VTIMING_SHIFT_EN
    logic [3:0] hoff_q, hoff_d;
    logic [3:0] voff_q, voff_d;

    function automatic logic [8:0] sext4(input logic [3:0] off);
        return {{5{off[3]}}, off};
    endfunction

    // Capture the offsets only on the frame wrap so a sync pulse is never split.
    always_comb begin
        hoff_d = hoff_q;
        voff_d = voff_q;
        if (pxl_cen && h_wrap_s && v_wrap_s) begin
            hoff_d = hoffset;
            voff_d = voffset;
        end else begin
            hoff_d = hoff_q;
            voff_d = voff_q;
        end
    end

    // Offset registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hoff_q <= 4'd0;
            voff_q <= 4'd0;
        end else begin
            hoff_q <= hoff_d;
            voff_q <= voff_d;
        end
    end

    assign hs_start_s = HS_START + sext4(hoff_q);
    assign hs_end_s   = HS_END   + sext4(hoff_q);
    assign vs_start_s = VS_START + sext4(voff_q);
    assign vs_end_s   = VS_END   + sext4(voff_q);
`else
    assign hs_start_s = HS_START;
    assign hs_end_s   = HS_END;
    assign vs_start_s = VS_START;
    assign vs_end_s   = VS_END;
`endif

    // Next-state counters and flags, all derived from the next counter value.
    always_comb begin
        hdump_d   = hdump_q;
        vdump_d   = vdump_q;
        vrender_d = vrender_q;
        hinit_d   = hinit_q;
        lhbl_d    = lhbl_q;
        lvbl_d    = lvbl_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        if (pxl_cen) begin
            hdump_d = cnt_next(hdump_q, HCNT_START, HCNT_END);
            hinit_d = (hdump_d == HINIT_POS);
            lhbl_d  = flag_update(lhbl_q, hdump_d, HB_END, HB_START);
            hs_d    = flag_update(hs_q, hdump_d, hs_start_s, hs_end_s);
            if (h_wrap_s) begin
                vdump_d   = cnt_next(vdump_q, VCNT_START, VCNT_END);
                vrender_d = cnt_next(vdump_d, VCNT_START, VCNT_END);
                lvbl_d    = flag_update(lvbl_q, vdump_d, VB_END, VB_START);
                vs_d      = flag_update(vs_q, vdump_d, vs_start_s, vs_end_s);
            end else begin
                vdump_d   = vdump_q;
                vrender_d = vrender_q;
                lvbl_d    = lvbl_q;
                vs_d      = vs_q;
            end
        end else begin
            hdump_d   = hdump_q;
            vdump_d   = vdump_q;
            vrender_d = vrender_q;
            hinit_d   = hinit_q;
            lhbl_d    = lhbl_q;
            lvbl_d    = lvbl_q;
            hs_d      = hs_q;
            vs_d      = vs_q;
        end
    end

    // State registers; reset parks the raster at the first pixel of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdump_q   <= HCNT_START;
            vdump_q   <= VCNT_START;
            vrender_q <= VCNT_START + 9'd1;
            hinit_q   <= 1'b0;
            lhbl_q    <= 1'b0;
            lvbl_q    <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            hdump_q   <= hdump_d;
            vdump_q   <= vdump_d;
            vrender_q <= vrender_d;
            hinit_q   <= hinit_d;
            lhbl_q    <= lhbl_d;
            lvbl_q    <= lvbl_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign hdump   = hdump_q;
    assign vdump   = vdump_q;
    assign vrender = vrender_q;
    assign hinit   = hinit_q;
    assign LHBL    = lhbl_q;
    assign LVBL    = lvbl_q;
    assign HS      = hs_q;
    assign VS      = vs_q;

endmodule
